// File: rtl/count_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : count_seq_ctrl                                               |
// | Description : Run/pause/abort count sequencer. Counts 0..period, then      |
// |               pulses done. Optional macro AUTO_RELOAD_EN allows            |
// |               back-to-back runs when start is seen in DONE.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module count_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] period,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period_q;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_period_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_period_nxt = r_period_q;
    case (r_state)
      c_IDLE: begin
        w_count_nxt = '0;
        if (start) begin
          w_period_nxt = period;
          w_state_nxt  = c_RUN;
        end
      end
      c_RUN: begin
        if (abort) begin
          w_state_nxt = c_IDLE;
          w_count_nxt = '0;
        end else if (pause) begin
          w_state_nxt = c_HOLD;
        end else if (r_count == r_period_q) begin
          w_state_nxt = c_DONE;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end
      c_HOLD: begin
        if (abort) begin
          w_state_nxt = c_IDLE;
          w_count_nxt = '0;
        end else if (!pause) begin
          // Resume edge only re-enters RUN; counting restarts on the next edge.
          w_state_nxt = c_RUN;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_count_nxt = '0;
`ifdef AUTO_RELOAD_EN
        if (start) begin
          w_period_nxt = period;
          w_state_nxt  = c_RUN;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_count    <= '0;
      r_period_q <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_period_q <= w_period_nxt;
      r_busy     <= (w_state_nxt == c_RUN) || (w_state_nxt == c_HOLD);
      r_done     <= (w_state_nxt == c_DONE);
    end
  end

  assign count_out = r_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_count_seq_ctrl                                            |
// | Description : Directed self-checking bench for count_seq_ctrl (WIDTH=4).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_count_seq_ctrl;

  localparam int c_W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [c_W-1:0] period = '0;
  logic           pause = 1'b0;
  logic           abort = 1'b0;
  logic [c_W-1:0] count_out;
  logic           busy;
  logic           done;
  logic [1:0]     state;

  int vectors = 0;
  int miscompares = 0;

  count_seq_ctrl #(.WIDTH(c_W)) dut (
    .clk(clk), .rst(rst), .start(start), .period(period), .pause(pause),
    .abort(abort), .count_out(count_out), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int cnt, input int bsy, input int dn);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".count"}, int'(count_out), cnt);
    chk({tag, ".busy"}, int'(busy), bsy);
    chk({tag, ".done"}, int'(done), dn);
  endtask

  initial begin
    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0);
    #10 rst = 1'b1;
    tick();
    chk_all("idle_after_reset", 0, 0, 0, 0);

    // Basic run, period 3; period change after acceptance is ignored
    start = 1'b1; period = 4'd3;
    tick();
    chk_all("basic_run0", 1, 0, 1, 0);
    start = 1'b0; period = 4'd9;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all("basic_run", 1, i, 1, 0);
    end
    tick();
    chk_all("basic_done", 3, 3, 0, 1);
    tick();
    chk_all("basic_idle", 0, 0, 0, 0);

    // Pause for 3 cycles at count 2, period 5
    start = 1'b1; period = 4'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_all("pause_pre", 1, 2, 1, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("pause_hold", 2, 2, 1, 0);
    end
    pause = 1'b0;
    tick();
    chk_all("pause_resume", 1, 2, 1, 0);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk_all("pause_run", 1, i, 1, 0);
    end
    tick();
    chk_all("pause_done", 3, 5, 0, 1);
    tick();
    chk_all("pause_idle", 0, 0, 0, 0);

    // start held during RUN is ignored; abort+pause in HOLD at count 4
    start = 1'b1; period = 4'd6;
    tick();
    period = 4'd1;
    for (int i = 1; i <= 4; i++) tick();
    chk_all("ignore_start", 1, 4, 1, 0);
    start = 1'b0; pause = 1'b1;
    tick();
    chk_all("abort_hold", 2, 4, 1, 0);
    abort = 1'b1;
    tick();
    chk_all("abort_idle", 0, 0, 0, 0);
    abort = 1'b0; pause = 1'b0;
    tick();
    chk_all("abort_nodone", 0, 0, 0, 0);

    // period = 0
    start = 1'b1; period = 4'd0;
    tick();
    chk_all("p0_run", 1, 0, 1, 0);
    start = 1'b0;
    tick();
    chk_all("p0_done", 3, 0, 0, 1);
    tick();
    chk_all("p0_idle", 0, 0, 0, 0);

    // period = max, no wrap
    start = 1'b1; period = 4'd15;
    tick();
    chk_all("pmax_run0", 1, 0, 1, 0);
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_all("pmax_run", 1, i, 1, 0);
    end
    tick();
    chk_all("pmax_done", 3, 15, 0, 1);
    tick();
    chk_all("pmax_idle", 0, 0, 0, 0);

    // Asynchronous reset between edges at count 7
    start = 1'b1; period = 4'd10;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    chk_all("areset_pre", 1, 7, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk_all("areset_async", 0, 0, 0, 0);
    #1 rst = 1'b1;
    tick();
    chk_all("areset_after", 0, 0, 0, 0);

    // start in DONE with period 2
    start = 1'b1; period = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk_all("reload_done", 3, 2, 0, 1);
    start = 1'b1; period = 4'd2;
    tick();
    start = 1'b0;
`ifdef AUTO_RELOAD_EN
    chk_all("reload_run", 1, 0, 1, 0);
    tick();
    tick();
    tick();
    chk_all("reload_done2", 3, 2, 0, 1);
    tick();
    chk_all("reload_idle", 0, 0, 0, 0);
`else
    chk_all("reload_idle", 0, 0, 0, 0);
    tick();
    chk_all("reload_still_idle", 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001: Parameter WIDTH, default 4, is the count width in bits.
REQ-002: Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003: Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004: Port start, input, 1 bit: request a run; sampled only in IDLE (and in DONE when AUTO_RELOAD_EN is defined).
REQ-005: Port period, input, WIDTH bits: terminal count for the run, latched when start is accepted.
REQ-006: Port pause, input, 1 bit: hold the count while high.
REQ-007: Port abort, input, 1 bit: terminate the current run.
REQ-008: Port count_out, output, WIDTH bits: current count value.
REQ-009: Port busy, output, 1 bit: high in RUN and HOLD.
REQ-010: Port done, output, 1 bit: high for exactly one cycle, in DONE.
REQ-011: Port state, output, 2 bits: FSM encoding IDLE=0, RUN=1, HOLD=2, DONE=3.

Function
REQ-012: FSM states are IDLE, RUN, HOLD and DONE; all outputs are registered.
REQ-013: IDLE behaviour:
- count_out = 0, busy = 0, done = 0.
- start = 1 latches period into period_q and moves to RUN next cycle, with count_out = 0.
REQ-014: RUN exits have this priority order:
- abort = 1 -> IDLE, count_out = 0.
- else pause = 1 -> HOLD, count_out unchanged.
- else count_out == period_q -> DONE, count_out unchanged.
- else count_out increments by 1 and the FSM stays in RUN.
REQ-015: HOLD behaviour:
- abort = 1 -> IDLE, count_out = 0.
- else pause = 0 -> RUN; no increment on that edge.
- else stay in HOLD with count_out held.
REQ-016: DONE behaviour:
- Lasts exactly one cycle, with done = 1 and count_out = period_q.
- Next state is IDLE with count_out = 0, unless REQ-022 applies.
REQ-017: Latency: start accepted at edge k with no pause gives RUN at k+1, count_out = period at k+1+period, done at k+2+period, and IDLE at k+3+period.
REQ-018: Boundary cases:
- period = 0 gives one RUN cycle, then DONE.
- period = 2^WIDTH-1 counts to the maximum value with no wrap to 0.
- count_out never exceeds period_q.
REQ-019: Input changes outside acceptance:
- start is ignored in RUN and HOLD.
- Changes on period after acceptance have no effect on the current run.
REQ-020: Simultaneous pause and abort: abort wins. Abort and pause are ignored in IDLE and DONE.

Reset
REQ-021: rst = 0 asynchronously forces the following, including mid-run or mid-hold; operation resumes on the first clk edge after rst rises:
- state = IDLE
- count_out = 0
- period_q = 0
- busy = 0
- done = 0

Configuration
REQ-022: Macro AUTO_RELOAD_EN controls back-to-back runs:
- Defined: start = 1 in DONE latches a new period and goes directly to RUN with count_out = 0, so runs execute with no IDLE gap.
- Undefined: start in DONE is ignored and DONE always returns to IDLE.

Verification
REQ-023: Basic run: start pulse with period = 3 -> count_out 0,1,2,3 in RUN, busy high for 4 cycles, then done = 1 for one cycle, then IDLE with count_out = 0.
REQ-024: Pause: period = 5, pause high for 3 cycles at count_out = 2 -> state = 2 and count_out = 2 throughout; resume gives 3,4,5, then done.
REQ-025: Abort during pause: abort = 1 and pause = 1 in the same cycle at count_out = 4 -> next cycle IDLE, count_out = 0, busy = 0, and no done pulse.
REQ-026: Range extremes:
- period = 0 -> one RUN cycle, then done.
- period = 15 (WIDTH = 4) -> count reaches 15, then done; count_out never wraps to 0 in RUN.
REQ-027: Asynchronous reset: rst low between clk edges at count_out = 7 -> outputs are 0 and state = 0 before the next edge.
REQ-028: AUTO_RELOAD_EN:
- Defined: start = 1 in DONE with period = 2 -> next cycle RUN with count_out = 0.
- Undefined: the same stimulus -> IDLE.
